// File: rtl/jtcontra_gfx_linemix.sv
// jtcontra_gfx_linemix: double-buffered CHR/SCR line RAMs with
// clear-after-read readout and two-layer priority mixing.
module jtcontra_gfx_linemix #(
  parameter int DW = 8,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl_cen,
  input  logic          LHBL,
  input  logic          LVBL,
  input  logic [AW-2:0] hdump,
  input  logic          line,
  input  logic          chr_we,
  input  logic          scr_we,
  input  logic [AW-1:0] line_addr,
  input  logic [DW-1:0] line_din,
  input  logic          chr_en,
  input  logic          scr_en,
  input  logic          prio,
  output logic          ready,
  output logic [DW-1:0] pxl,
  output logic [1:0]    pxl_lyr,
  output logic          LHBL_dly,
  output logic          LVBL_dly
);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t st, st_nx;

  logic [DW-1:0] chr_ram [2**AW];
  logic [DW-1:0] scr_ram [2**AW];

  logic [AW-1:0] cnt;
  logic [AW-1:0] rd;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] b_addr;
  logic          b_we;
  logic          clr_pend;
  logic          rd_en;
  logic [DW-1:0] chr_q;
  logic [DW-1:0] scr_q;
  logic          hb_s0;
  logic          vb_s0;
  logic          chr_op;
  logic          scr_op;
  logic [DW-1:0] mix_pxl;
  logic [1:0]    mix_lyr;

  assign rd_addr = {~line, hdump};
  assign rd_en   = (st == RUN) && pxl_cen;
  assign b_we    = (st == INIT) || clr_pend;
  assign b_addr  = (st == INIT) ? cnt : rd;

  always_comb begin
    st_nx = st;
    if (st == INIT && cnt == {AW{1'b1}})
      st_nx = RUN;
  end

  // Port B is listed last so the sweep wins over a renderer write
  always_ff @(posedge clk) begin
    if (chr_we)
      chr_ram[line_addr] <= line_din;
    if (scr_we)
      scr_ram[line_addr] <= line_din;
    if (b_we) begin
      chr_ram[b_addr] <= '0;
      scr_ram[b_addr] <= '0;
    end
    if (rd_en) begin
      chr_q <= chr_ram[rd_addr];
      scr_q <= scr_ram[rd_addr];
    end
  end

  assign chr_op = chr_en && (chr_q[3:0] != 4'd0);
  assign scr_op = scr_en && (scr_q[3:0] != 4'd0);

  always_comb begin
    mix_pxl = '0;
    mix_lyr = 2'b00;
    if (hb_s0 && vb_s0) begin
      if (prio) begin
        if (scr_op) begin
          mix_pxl = scr_q;
          mix_lyr = 2'b01;
        end else if (chr_op) begin
          mix_pxl = chr_q;
          mix_lyr = 2'b10;
        end
      end else begin
        if (chr_op) begin
          mix_pxl = chr_q;
          mix_lyr = 2'b10;
        end else if (scr_op) begin
          mix_pxl = scr_q;
          mix_lyr = 2'b01;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= INIT;
      cnt      <= '0;
      ready    <= 1'b0;
      rd       <= '0;
      clr_pend <= 1'b0;
      hb_s0    <= 1'b0;
      vb_s0    <= 1'b0;
      pxl      <= '0;
      pxl_lyr  <= 2'b00;
      LHBL_dly <= 1'b0;
      LVBL_dly <= 1'b0;
    end else begin
      st       <= st_nx;
      clr_pend <= 1'b0;
      if (st == INIT) begin
        cnt <= cnt + 1'b1;
        if (st_nx == RUN)
          ready <= 1'b1;
      end else if (pxl_cen) begin
        rd       <= rd_addr;
        hb_s0    <= LHBL;
        vb_s0    <= LVBL;
        clr_pend <= LHBL && LVBL;
        pxl      <= mix_pxl;
        pxl_lyr  <= mix_lyr;
        LHBL_dly <= hb_s0;
        LVBL_dly <= vb_s0;
      end
    end
  end

endmodule
